req_pend_latch: RTL
===================

Name: req_pend_latch

Overview:
- Upstream request-capture stage for the 4:2 priority encoder.
- Detects rising edges on 4 raw request lines and holds them in a sticky pending register. That register drives the encoder's 4-bit input `y`.
- Takes the encoder's 2-bit output `a` back, turns it into a registered grant with a valid/ready handshake, and clears the served pending bit on acceptance.
- Encoder rule, fixed: highest set bit wins.

Parameters:
- N, 4, number of request lines; this spec and the test plan cover only N = 4.
- IDX_W, 2, width of the encoded index; must equal clog2(N).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req_in  input  N  raw request lines; synchronous to clk.
- pend_y  output  N  pending register; connects to encoder `y`.
- enc_a  input  IDX_W  encoder `a` output; must be the combinational encoding of pend_y.
- grant_valid  output  1  a grant is offered.
- grant_idx  output  IDX_W  index of the offered grant.
- grant_ready  input  1  consumer accepts the grant.
- overflow  output  1  sticky flag; a request edge arrived while that line was already pending.

Behaviour:
- Reset, while rst = 1 at a clock edge:
  - pend_y = 0, grant_valid = 0, grant_idx = 0, overflow = 0, FSM = IDLE.
  - req_prev is loaded with the current req_in, so a line held high through reset does not produce an edge.
  - Reset mid-offer drops the grant with no clear side effects.
- Edge detect:
  - rise = req_in & ~req_prev.
  - req_prev <= req_in every cycle.
- Pending update, each cycle:
  - pend_next = (pend_y & ~clr_mask) | rise.
  - clr_mask is one-hot(grant_idx) when grant_valid & grant_ready, otherwise 0.
  - Set wins: a rise on the bit being cleared in the same cycle leaves that bit pending.
- Overflow:
  - Set when any bit is in (rise & pend_y & ~clr_mask).
  - Cleared only by rst.
- FSM with 2 states:
  - IDLE:
    - grant_valid = 0.
    - If pend_y != 0: grant_idx <= enc_a, grant_valid <= 1, go to OFFER.
  - OFFER:
    - grant_valid = 1; grant_idx is held stable.
    - On grant_valid & grant_ready: clear that pending bit, grant_valid <= 0, go to IDLE.
    - A higher-priority request arriving during OFFER does not pre-empt the current offer.
- Latency:
  - A rise at edge k makes pend_y valid after edge k.
  - grant_valid asserts after edge k+1, i.e. 2 cycles from req_in to grant.
  - There is 1 idle bubble between back-to-back grants, so sustained throughput is one grant per 2 cycles.
- grant_ready while grant_valid = 0 is ignored.
- enc_a is sampled only in IDLE. Its value when pend_y = 0 is don't-care.

Optional Feature:
- Macro: REQ_LEVEL_EN.
- When defined:
  - Requests are level-sensitive: rise is replaced by req_in.
  - A line held high re-pends immediately after being cleared.
  - overflow is tied to 0.
- When undefined: edge-sensitive behaviour as described above.

Test Plan:
- Reset with req_in = 4'b0001 held high, then released -> pend_y = 0000, no grant; overflow = 0 throughout.
- req_in 0000→0100 at cycle 1, grant_ready = 1 -> pend_y = 0100 after 1 edge, grant_valid = 1 with grant_idx = 2 after 2 edges; pend_y = 0000 and grant_valid = 0 after acceptance.
- req_in 0000→0101 at once, grant_ready = 1 -> grant_idx = 2 first, then grant_idx = 0; exactly 2 grants, 1 idle cycle between them.
- Offer idx 0 with grant_ready = 0 for 5 cycles while req_in rises on bit 3 -> grant_idx stays 0 until accepted; the next grant is idx 3.
- Bit 1 pending and ungranted; req_in[1] 1→0→1 -> overflow = 1 and stays 1; pend_y[1] = 1; only one grant for idx 1.
- Accept of idx 1 in the same cycle as a new rise on req_in[1] -> pend_y[1] stays 1, overflow stays 0, a second grant for idx 1 follows.
- With REQ_LEVEL_EN defined, req_in = 1000 held -> grant idx 3 repeats every 2 cycles while grant_ready = 1.

Source files
------------

// File: rtl/req_pend_latch_if.sv
// Request/pending/grant bundle between the request-capture stage and its
// environment (raw request lines, 4:2 encoder loop, grant consumer).
interface req_pend_latch_if #(
  parameter int N     = 4,
  parameter int IDX_W = 2
);
  logic [N-1:0]     req_in;
  logic [N-1:0]     pend_y;
  logic [IDX_W-1:0] enc_a;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_ready;
  logic             overflow;

  // master: the capture stage itself; slave: requesters, encoder and consumer
  modport master (
    input  req_in, enc_a, grant_ready,
    output pend_y, grant_valid, grant_idx, overflow
  );

  modport slave (
    output req_in, enc_a, grant_ready,
    input  pend_y, grant_valid, grant_idx, overflow
  );
endinterface

// File: rtl/req_pend_latch.sv
// Request edge capture into a sticky pending register feeding a 4:2 encoder,
// with a registered valid/ready grant. REQ_LEVEL_EN selects level-sensitive requests.
module req_pend_latch #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  req_pend_latch_if.master  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [N-1:0]     pend_reg, pend_next;
  logic [N-1:0]     rise;
  logic [N-1:0]     clr_mask;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             ovf_reg, ovf_next;
  logic             accept;

  assign accept = (state_reg == OFFER) && bus.grant_ready;

  for (genvar gi = 0; gi < N; gi++) begin : g_clr
    assign clr_mask[gi] = accept && (idx_reg == IDX_W'(gi));
  end

`ifdef REQ_LEVEL_EN
  assign rise     = bus.req_in;
  assign ovf_next = 1'b0;
`else
  logic [N-1:0] req_prev_reg;

  // Loaded during reset too, so a line held high through reset yields no edge.
  always_ff @(posedge clk) begin
    req_prev_reg <= bus.req_in;
  end

  assign rise     = bus.req_in & ~req_prev_reg;
  assign ovf_next = ovf_reg | (|(rise & pend_reg & ~clr_mask));
`endif

  // Set wins over clear on the same bit.
  assign pend_next = (pend_reg & ~clr_mask) | rise;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (|pend_reg) begin
          state_next = OFFER;
          idx_next   = bus.enc_a;
        end
      end
      OFFER: begin
        if (bus.grant_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pend_reg  <= '0;
      idx_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      idx_reg   <= idx_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign bus.pend_y      = pend_reg;
  assign bus.grant_valid = (state_reg == OFFER);
  assign bus.grant_idx   = idx_reg;
  assign bus.overflow    = ovf_reg;

endmodule
